// File: rtl/mmio_rd_arbiter.sv
// mmio_rd_arbiter
//   Two-requester read arbiter in front of the MMIO AXI4 read path (AR/R).
//   Round-robin grant, one burst in flight. Each burst is tagged with an ID
//   derived from the granted requester, and R beats are routed back to it.
//   Burst length and R ID are checked; any violation sets a sticky err flag.
// Ports
//   clock, reset_n              : clock, asynchronous active-low reset
//   reqN_ar_valid/ready/addr/len: requester read-address channels (N = 0,1)
//   reqN_r_valid/ready/data/resp/last : requester read-data channels
//   m_ar_valid/ready/id/addr/len: master read-address channel (registered)
//   m_r_valid/ready/id/data/resp/last : master read-data channel
//   busy                        : transaction in progress (ADDR or DATA)
//   err                         : sticky protocol error (length or ID mismatch)
module mmio_rd_arbiter #(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // requester 0
  input  logic              req0_ar_valid,
  output logic              req0_ar_ready,
  input  logic [ADDR_W-1:0] req0_ar_addr,
  input  logic [LEN_W-1:0]  req0_ar_len,
  output logic              req0_r_valid,
  input  logic              req0_r_ready,
  output logic [DATA_W-1:0] req0_r_data,
  output logic [1:0]        req0_r_resp,
  output logic              req0_r_last,
  // requester 1
  input  logic              req1_ar_valid,
  output logic              req1_ar_ready,
  input  logic [ADDR_W-1:0] req1_ar_addr,
  input  logic [LEN_W-1:0]  req1_ar_len,
  output logic              req1_r_valid,
  input  logic              req1_r_ready,
  output logic [DATA_W-1:0] req1_r_data,
  output logic [1:0]        req1_r_resp,
  output logic              req1_r_last,
  // master side
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  output logic [ID_W-1:0]   m_ar_id,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [LEN_W-1:0]  m_ar_len,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  input  logic [ID_W-1:0]   m_r_id,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_last,
  // status
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             rr_ptr;     // preferred requester when both request
  logic             grant;      // owner of the current burst
  logic [LEN_W-1:0] beat_cnt;

  logic             win_valid;
  logic             win_idx;
  logic             r_hs;
  logic             len_hit;

  // Arbitration: only meaningful in IDLE.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 1'b0;
    if (state == IDLE) begin
      if (req0_ar_valid && req1_ar_valid) begin
        win_valid = 1'b1;
        win_idx   = rr_ptr;
      end else if (req0_ar_valid) begin
        win_valid = 1'b1;
        win_idx   = 1'b0;
      end else if (req1_ar_valid) begin
        win_valid = 1'b1;
        win_idx   = 1'b1;
      end
    end
  end

  assign req0_ar_ready = win_valid && !win_idx;
  assign req1_ar_ready = win_valid &&  win_idx;

  assign m_ar_valid = (state == ADDR);
  assign m_ar_id    = {{(ID_W-1){1'b0}}, grant};
  assign busy       = (state != IDLE);

  assign m_r_ready    = (state == DATA) && (grant ? req1_r_ready : req0_r_ready);
  assign req0_r_valid = (state == DATA) && !grant && m_r_valid;
  assign req1_r_valid = (state == DATA) &&  grant && m_r_valid;

  assign req0_r_data = m_r_data;
  assign req0_r_resp = m_r_resp;
  assign req0_r_last = m_r_last;
  assign req1_r_data = m_r_data;
  assign req1_r_resp = m_r_resp;
  assign req1_r_last = m_r_last;

  assign r_hs    = (state == DATA) && m_r_valid && m_r_ready;
  assign len_hit = (beat_cnt == m_ar_len);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid)          state_nxt = ADDR;
      ADDR:    if (m_ar_ready)         state_nxt = DATA;
      DATA:    if (r_hs && m_r_last)   state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      grant     <= 1'b0;
      m_ar_addr <= '0;
      m_ar_len  <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_valid) begin
        grant     <= win_idx;
        m_ar_addr <= win_idx ? req1_ar_addr : req0_ar_addr;
        m_ar_len  <= win_idx ? req1_ar_len  : req0_ar_len;
      end
      if (state == ADDR && m_ar_ready) begin
        beat_cnt <= '0;
      end
      if (r_hs) begin
        if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if ((m_r_id != m_ar_id) || (m_r_last && !len_hit) || (!m_r_last && len_hit)) begin
          err <= 1'b1;
        end
        if (m_r_last) begin
          rr_ptr <= ~grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_rd_arbiter.sv
module tb_mmio_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_ar_valid, req0_ar_ready;
  logic [30:0] req0_ar_addr;
  logic [7:0]  req0_ar_len;
  logic        req0_r_valid, req0_r_ready;
  logic [63:0] req0_r_data;
  logic [1:0]  req0_r_resp;
  logic        req0_r_last;
  logic        req1_ar_valid, req1_ar_ready;
  logic [30:0] req1_ar_addr;
  logic [7:0]  req1_ar_len;
  logic        req1_r_valid, req1_r_ready;
  logic [63:0] req1_r_data;
  logic [1:0]  req1_r_resp;
  logic        req1_r_last;
  logic        m_ar_valid, m_ar_ready;
  logic [3:0]  m_ar_id;
  logic [30:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic        m_r_valid, m_r_ready;
  logic [3:0]  m_r_id;
  logic [63:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  logic        busy, err;

  always #5 clock = ~clock;

  mmio_rd_arbiter #(.ADDR_W(31), .DATA_W(64), .LEN_W(8), .ID_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_ar_valid(req0_ar_valid), .req0_ar_ready(req0_ar_ready),
    .req0_ar_addr(req0_ar_addr), .req0_ar_len(req0_ar_len),
    .req0_r_valid(req0_r_valid), .req0_r_ready(req0_r_ready),
    .req0_r_data(req0_r_data), .req0_r_resp(req0_r_resp), .req0_r_last(req0_r_last),
    .req1_ar_valid(req1_ar_valid), .req1_ar_ready(req1_ar_ready),
    .req1_ar_addr(req1_ar_addr), .req1_ar_len(req1_ar_len),
    .req1_r_valid(req1_r_valid), .req1_r_ready(req1_r_ready),
    .req1_r_data(req1_r_data), .req1_r_resp(req1_r_resp), .req1_r_last(req1_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .busy(busy), .err(err)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  // Reference model state: who is preferred next, and the expected sticky error.
  int   rr_pref  = 0;
  logic err_exp  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: arbitration, AR phase (with ar_wait stall cycles),
  // and a data phase where the slave returns nbeats beats (last on the final one).
  // rmode: 0 = r_ready always 1, 1 = toggles 1/0, 2 = random.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [30:0] a0, input logic [30:0] a1,
                         input logic [7:0] l0, input logic [7:0] l1,
                         input int ar_wait, input int nbeats, input int rmode,
                         input logic bad_id);
    int          w;
    int          got;
    int          cyc;
    logic        rr;
    logic [30:0] ea;
    logic [7:0]  el;
    logic [3:0]  wid;
    w   = (v0 && v1) ? rr_pref : (v0 ? 0 : 1);
    ea  = (w == 1) ? a1 : a0;
    el  = (w == 1) ? l1 : l0;
    wid = 4'(w);
    req0_ar_valid = v0; req0_ar_addr = a0; req0_ar_len = l0;
    req1_ar_valid = v1; req1_ar_addr = a1; req1_ar_len = l1;
    #1;
    chk("ar_ready0", req0_ar_ready, w == 0);
    chk("ar_ready1", req1_ar_ready, w == 1);
    chk("busy_idle", busy, 0);
    @(posedge clock); #1;
    if (w == 0) req0_ar_valid = 1'b0; else req1_ar_valid = 1'b0;
    for (int i = 0; i < ar_wait; i++) begin
      #1;
      chk("ar_valid_stall", m_ar_valid, 1);
      chk("ar_addr_stall", m_ar_addr, ea);
      chk("ar_len_stall", m_ar_len, el);
      chk("ar_id_stall", m_ar_id, wid);
      chk("ar_ready0_stall", req0_ar_ready, 0);
      chk("ar_ready1_stall", req1_ar_ready, 0);
      @(posedge clock); #1;
    end
    m_ar_ready = 1'b1;
    #1;
    chk("ar_valid", m_ar_valid, 1);
    chk("ar_addr", m_ar_addr, ea);
    chk("ar_len", m_ar_len, el);
    chk("ar_id", m_ar_id, wid);
    chk("busy_addr", busy, 1);
    @(posedge clock); #1;
    m_ar_ready = 1'b0;
    got = 0;
    cyc = 0;
    while (got < nbeats && cyc < 400) begin
      m_r_valid = ($urandom_range(0, 3) != 0);
      m_r_data  = {$urandom, $urandom};
      m_r_resp  = 2'($urandom_range(0, 3));
      m_r_last  = (got == nbeats - 1);
      m_r_id    = bad_id ? (wid ^ 4'h8) : wid;
      rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      if (w == 0) begin req0_r_ready = rr; req1_r_ready = 1'($urandom_range(0, 1)); end
      else        begin req1_r_ready = rr; req0_r_ready = 1'($urandom_range(0, 1)); end
      #1;
      chk("m_r_ready", m_r_ready, rr);
      chk("r_valid_owner", (w == 0) ? req0_r_valid : req1_r_valid, m_r_valid);
      chk("r_valid_other", (w == 0) ? req1_r_valid : req0_r_valid, 0);
      chk("r_data", (w == 0) ? req0_r_data : req1_r_data, m_r_data);
      chk("r_resp", (w == 0) ? req0_r_resp : req1_r_resp, m_r_resp);
      chk("r_last", (w == 0) ? req0_r_last : req1_r_last, m_r_last);
      chk("busy_data", busy, 1);
      if (m_r_valid && rr) got++;
      @(posedge clock); #1;
      cyc++;
    end
    chk("beats_delivered", got, nbeats);
    m_r_valid = 1'b0; m_r_last = 1'b0;
    req0_r_ready = 1'b0; req1_r_ready = 1'b0;
    req0_ar_valid = 1'b0; req1_ar_valid = 1'b0;
    if ((nbeats != int'(el) + 1) || bad_id) err_exp = 1'b1;
    rr_pref = 1 - w;
    #1;
    chk("busy_end", busy, 0);
    chk("err", err, err_exp);
  endtask

  initial begin
    reset_n = 1'b0;
    req0_ar_valid = 0; req0_ar_addr = '0; req0_ar_len = '0; req0_r_ready = 0;
    req1_ar_valid = 0; req1_ar_addr = '0; req1_ar_len = '0; req1_r_ready = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_m_ar_addr", m_ar_addr, 0);
    chk("rst_m_ar_len", m_ar_len, 0);
    chk("rst_m_ar_id", m_ar_id, 0);
    chk("rst_m_r_ready", m_r_ready, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Simultaneous requests after reset: req0 first, then alternation.
    run_txn(1, 1, 31'h1000_0040, 31'h1000_0080, 8'd1, 8'd2, 0, 2, 0, 0);
    run_txn(1, 1, 31'h1000_0040, 31'h1000_0080, 8'd1, 8'd2, 0, 3, 0, 0);
    run_txn(1, 1, 31'h1000_00c0, 31'h1000_0100, 8'd0, 8'd0, 0, 1, 0, 0);
    // req0 alone, len 3.
    run_txn(1, 0, 31'h1000_0000, 31'h0, 8'd3, 8'd0, 0, 4, 0, 0);
    // AR stall for 5 cycles.
    run_txn(0, 1, 31'h0, 31'h2345_6788, 8'd0, 8'd2, 5, 3, 0, 0);
    // req1 len 7 with toggling r_ready.
    run_txn(0, 1, 31'h0, 31'h1000_0200, 8'd0, 8'd7, 0, 8, 1, 0);

    // Stray master R beat while idle: not accepted, not flagged.
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 4'h3; req0_r_ready = 1'b1; req1_r_ready = 1'b1;
    #1;
    chk("stray_m_r_ready", m_r_ready, 0);
    chk("stray_r_valid0", req0_r_valid, 0);
    chk("stray_r_valid1", req1_r_valid, 0);
    @(posedge clock); #1;
    m_r_valid = 1'b0; m_r_last = 1'b0; req0_r_ready = 1'b0; req1_r_ready = 1'b0;
    chk("stray_err", err, err_exp);
    chk("stray_busy", busy, 0);

    // Early last: len 3 but only 3 beats -> sticky err.
    run_txn(1, 0, 31'h1000_0300, 31'h0, 8'd3, 8'd0, 0, 3, 0, 0);
    run_txn(0, 1, 31'h0, 31'h1000_0400, 8'd0, 8'd2, 1, 3, 2, 0);
    run_txn(1, 1, 31'h1000_0500, 31'h1000_0600, 8'd1, 8'd1, 0, 2, 2, 0);

    // Reset in the middle of a data phase.
    req1_ar_valid = 1'b1; req1_ar_addr = 31'h1000_0700; req1_ar_len = 8'd3;
    @(posedge clock); #1;
    req1_ar_valid = 1'b0; m_ar_ready = 1'b1;
    @(posedge clock); #1;
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_id = 4'h1; req1_r_ready = 1'b1;
    #1;
    chk("mid_r_valid1", req1_r_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_r_valid1", req1_r_valid, 0);
    chk("mid_rst_r_valid0", req0_r_valid, 0);
    chk("mid_rst_m_r_ready", m_r_ready, 0);
    chk("mid_rst_m_ar_valid", m_ar_valid, 0);
    chk("mid_rst_err", err, 0);
    m_r_valid = 1'b0; req1_r_ready = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    err_exp = 1'b0;
    rr_pref = 0;
    @(posedge clock); #1;
    run_txn(1, 1, 31'h1000_0800, 31'h1000_0900, 8'd2, 8'd2, 0, 3, 0, 0);

    // Wrong R id: flagged.
    run_txn(0, 1, 31'h0, 31'h1000_0a00, 8'd0, 8'd1, 0, 2, 0, 1);

    // Randomized well-formed traffic after a reset clears err.
    reset_n = 1'b0;
    #1;
    chk("rst2_err", err, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    err_exp = 1'b0;
    rr_pref = 0;
    @(posedge clock); #1;
    for (int t = 0; t < 10; t++) begin
      logic v0, v1;
      logic [7:0] l0, l1;
      int sel;
      sel = $urandom_range(1, 3);
      v0 = sel[0];
      v1 = sel[1];
      l0 = 8'($urandom_range(0, 7));
      l1 = 8'($urandom_range(0, 7));
      run_txn(v0, v1, 31'($urandom), 31'($urandom), l0, l1,
              $urandom_range(0, 3), (v0 && !v1) || (v0 && v1 && rr_pref == 0) ? int'(l0) + 1 : int'(l1) + 1,
              2, 0);
    end
    // One more with a long burst: beat after len without last -> err.
    run_txn(1, 0, 31'h1000_0b00, 31'h0, 8'd1, 8'd0, 0, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
